ifu_fetch: RTL and testbench
============================

# ifu_fetch

Instruction fetch unit for the ares pipeline. It owns the program counter and issues word fetches to instruction memory over a request/grant/response handshake. Returned instructions are buffered in a small in-order FIFO and presented, with their PC, to the decode stage (control decode and immediate generation) through a valid/ready interface. Branch/jump redirects flush the buffer and discard in-flight responses.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC fetched first after reset; bits [1:0] must be 0.
- `DEPTH`, default 2: instruction FIFO depth and the maximum number of outstanding requests. Must be a power of 2, ≥2.
- `clk_i`  in  1  clock; all state updates on the rising edge.
- `rst_n_i`  in  1  reset, synchronous, active-low.
- `imem_req_o`  out  1  fetch request valid.
- `imem_addr_o`  out  32  fetch byte address; always word aligned.
- `imem_gnt_i`  in  1  request accepted in this cycle when `imem_req_o` is also high.
- `imem_rvalid_i`  in  1  response valid; responses return in request order, at least 1 cycle after grant.
- `imem_rdata_i`  in  32  instruction word.
- `redirect_i`  in  1  flush and restart fetch.
- `redirect_pc_i`  in  32  restart address; bits [1:0] ignored and treated as 00.
- `id_valid_o`  out  1  decode-side instruction valid.
- `id_ready_i`  in  1  decode stage accepts the instruction.
- `id_inst_o`  out  32  instruction word to decode.
- `id_pc_o`  out  32  address of `id_inst_o`.

## Operation
- State:
  - `pc`: next address to request.
  - `resp_pc`: address of the next expected non-dropped response.
  - `out_cnt`: outstanding granted requests, 0..DEPTH.
  - `drop_cnt`: responses still to discard, 0..DEPTH.
  - FIFO of {inst, pc}, with `count` 0..DEPTH.
- Reset (`rst_n_i`=0 at the edge): `pc`=`resp_pc`=RESET_PC; all counters 0; FIFO entries cleared to 0. While reset is low, `imem_req_o`=0, `id_valid_o`=0, `id_inst_o`=0, `id_pc_o`=0.
- `pop` = `id_valid_o` & `id_ready_i`.
- Request: `imem_req_o` = ~`redirect_i` & (`count`+`out_cnt`+`drop_cnt` < DEPTH, or that sum equals DEPTH and `pop`). `imem_addr_o` = `pc`.
- On `imem_req_o` & `imem_gnt_i`: `pc` += 4 (wraps modulo 2^32), `out_cnt` += 1.
- Response handling when `imem_rvalid_i`:
  - If `drop_cnt`>0: decrement `drop_cnt`; data discarded.
  - Otherwise: decrement `out_cnt`, push {`imem_rdata_i`, `resp_pc`}, then `resp_pc` += 4.
  - Same-cycle grant and response net `out_cnt` unchanged.
- Credit rule guarantees a push never meets a full FIFO. An `imem_rvalid_i` with `out_cnt`+`drop_cnt`=0 is a protocol error: ignored, no state change.
- FIFO output: `id_valid_o` = (`count`≠0); `id_inst_o`/`id_pc_o` show the head entry. Push and pop in the same cycle leave `count` unchanged.
- Redirect (highest priority) in the cycle `redirect_i`=1:
  - FIFO emptied; any pop or push that cycle is void.
  - `drop_cnt` ← `drop_cnt` + `out_cnt` − (1 if `imem_rvalid_i`), so a response arriving in the redirect cycle is discarded. `out_cnt` ← 0.
  - `pc` and `resp_pc` ← {`redirect_pc_i`[31:2], 2'b00}.
  - No request is issued in the redirect cycle.
- Back-to-back redirects: the last one wins; `drop_cnt` accumulates per the rule above.

## Timing
- Request address is combinational from the `pc` register. The first request is asserted in the first cycle after reset deasserts.
- Response accepted in cycle n → `id_valid_o` high in cycle n+1. There is no bypass.
- Redirect in cycle n → first request to the new PC in cycle n+1. Its instruction reaches decode no earlier than cycle n+3 with 1-cycle memory.
- Sustained throughput with zero-wait memory (grant same cycle, response next cycle) and `id_ready_i`=1: one instruction per cycle.
- `id_valid_o`, `id_inst_o` and `id_pc_o` are stable while `id_valid_o`=1 and `id_ready_i`=0, unless a redirect or reset occurs.
- Reset mid-operation: all state returns to reset values at that edge. The bench's memory model must also drop its in-flight responses.

## Test plan
- Reset, then 1-cycle memory with `gnt`=1 and `id_ready_i`=1 → requests 0x0, 0x4, 0x8, … on consecutive cycles. `id_valid_o` rises on cycle 2 with pc 0x0, then one instruction per cycle in order.
- `id_ready_i`=0 for 10 cycles → FIFO fills to DEPTH, `imem_req_o` drops. Head stays pc 0x0 / same inst. Releasing ready resumes in order with no loss or duplication.
- Memory with 3-cycle response latency, 2 requests outstanding, `redirect_i`=1 with `redirect_pc_i`=0x100 → both stale responses are dropped. The first `id_pc_o` delivered is 0x100 with the word returned for address 0x100.
- `redirect_i` coincides with `imem_rvalid_i` and a pop; `redirect_pc_i`=0x203 → FIFO empty next cycle, response discarded, next request address 0x200.
- `gnt` held low for 5 cycles → `imem_req_o` and `imem_addr_o` stay stable, `pc` does not advance. PC wrap: redirect to 0xFFFF_FFFC → next two requests are 0xFFFF_FFFC, then 0x0000_0000.
- `rst_n_i` low for 1 cycle mid-stream with 2 outstanding → all outputs 0 during reset. Fetch restarts at RESET_PC and no pre-reset instruction appears at decode.

Source files
------------

// File: rtl/ifu_fetch.sv
// Instruction fetch unit: owns the PC, issues credit-limited word fetches and
// buffers returned instructions in an in-order FIFO for the decode stage.
module ifu_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        id_valid_o,
  input  logic        id_ready_i,
  output logic [31:0] id_inst_o,
  output logic [31:0] id_pc_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned SW = CW + 2;
  localparam logic [SW-1:0] DEPTH_S = SW'(DEPTH);

  logic [31:0]   pc_q;
  logic [31:0]   resp_pc_q;
  logic [CW-1:0] out_cnt_q;
  logic [CW-1:0] drop_cnt_q;
  logic [CW-1:0] count_q;
  logic [PW-1:0] rd_ptr_q;
  logic [PW-1:0] wr_ptr_q;
  logic [31:0]   fifo_inst [DEPTH];
  logic [31:0]   fifo_pc   [DEPTH];

  logic [SW-1:0] credit_sum;
  logic [31:0]   redir_pc;
  logic          pop;
  logic          grant;
  logic          rsp_ok;
  logic          rsp_drop;
  logic          push;

  always_comb begin
    redir_pc    = redirect_pc_i & ~32'd3;
    id_valid_o  = rst_n_i & (count_q != '0);
    id_inst_o   = rst_n_i ? fifo_inst[rd_ptr_q] : '0;
    id_pc_o     = rst_n_i ? fifo_pc[rd_ptr_q]   : '0;
    pop         = id_valid_o & id_ready_i;
    // Every slot the FIFO might need is counted: buffered, in flight, and to be dropped.
    credit_sum  = SW'(count_q) + SW'(out_cnt_q) + SW'(drop_cnt_q);
    imem_req_o  = rst_n_i & ~redirect_i &
                  ((credit_sum < DEPTH_S) | ((credit_sum == DEPTH_S) & pop));
    imem_addr_o = pc_q;
    grant       = imem_req_o & imem_gnt_i;
    // A response with nothing outstanding is a protocol error and is ignored.
    rsp_ok      = imem_rvalid_i & ((out_cnt_q != '0) | (drop_cnt_q != '0));
    rsp_drop    = rsp_ok & (drop_cnt_q != '0);
    push        = rsp_ok & (drop_cnt_q == '0);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      pc_q       <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      out_cnt_q  <= '0;
      drop_cnt_q <= '0;
      count_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        fifo_inst[i] <= '0;
        fifo_pc[i]   <= '0;
      end
    end else if (redirect_i) begin
      pc_q       <= redir_pc;
      resp_pc_q  <= redir_pc;
      drop_cnt_q <= drop_cnt_q + out_cnt_q - CW'(rsp_ok);
      out_cnt_q  <= '0;
      count_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
    end else begin
      if (grant) begin
        pc_q <= pc_q + 32'd4;
      end
      out_cnt_q <= out_cnt_q + CW'(grant) - CW'(push);
      if (rsp_drop) begin
        drop_cnt_q <= drop_cnt_q - 1'b1;
      end
      if (push) begin
        fifo_inst[wr_ptr_q] <= imem_rdata_i;
        fifo_pc[wr_ptr_q]   <= resp_pc_q;
        wr_ptr_q            <= wr_ptr_q + 1'b1;
        resp_pc_q           <= resp_pc_q + 32'd4;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      count_q <= count_q + CW'(push) - CW'(pop);
    end
  end

endmodule

// File: tb/tb_ifu_fetch.sv
// Scoreboard bench for ifu_fetch: granted fetch addresses form the expected
// decode stream, emptied on redirect or reset; a monitor checks each delivery.
module tb_ifu_fetch;

  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n_i = 1'b0;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i = 1'b0;
  logic        imem_rvalid_i = 1'b0;
  logic [31:0] imem_rdata_i = '0;
  logic        redirect_i = 1'b0;
  logic [31:0] redirect_pc_i = '0;
  logic        id_valid_o;
  logic        id_ready_i = 1'b0;
  logic [31:0] id_inst_o;
  logic [31:0] id_pc_o;

  ifu_fetch #(.RESET_PC(RST_PC), .DEPTH(2)) dut (
    .clk_i(clk), .rst_n_i(rst_n_i),
    .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o), .imem_gnt_i(imem_gnt_i),
    .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i),
    .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
    .id_valid_o(id_valid_o), .id_ready_i(id_ready_i),
    .id_inst_o(id_inst_o), .id_pc_o(id_pc_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int unsigned due;
  } mreq_t;

  mreq_t       memq[$];
  logic [31:0] exp_q[$];
  logic [31:0] model_pc = RST_PC;
  int unsigned cyc = 0;
  int unsigned gnt_pct = 100, rdy_pct = 100, lat_min = 1, lat_max = 1;
  int unsigned n_checks = 0, n_fail = 0, n_pops = 0;
  logic [31:0] last_pop_pc = '0;
  logic        s_req, s_rvalid, s_pop;
  logic [31:0] s_addr;

  function automatic logic [31:0] memword(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h3c5a_96e1;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock cycle: drive inputs at negedge, record grants, update models after posedge.
  task automatic step(input bit redir, input logic [31:0] rpc, input bit rstn);
    @(negedge clk);
    rst_n_i       = rstn;
    redirect_i    = redir;
    redirect_pc_i = rpc;
    imem_gnt_i    = ($urandom_range(99) < gnt_pct);
    id_ready_i    = ($urandom_range(99) < rdy_pct);
    if (rstn && memq.size() > 0 && memq[0].due <= cyc) begin
      imem_rvalid_i = 1'b1;
      imem_rdata_i  = memword(memq[0].addr);
    end else begin
      imem_rvalid_i = 1'b0;
      imem_rdata_i  = $urandom;
    end
    #1;
    s_req    = imem_req_o;
    s_addr   = imem_addr_o;
    s_rvalid = imem_rvalid_i;
    s_pop    = id_valid_o & id_ready_i;
    if (!rstn) begin
      chk("rst_req", {31'd0, imem_req_o}, 32'd0);
      chk("rst_valid", {31'd0, id_valid_o}, 32'd0);
      chk("rst_inst", id_inst_o, 32'd0);
      chk("rst_pc", id_pc_o, 32'd0);
    end else if (imem_req_o && imem_gnt_i) begin
      chk("fetch_addr", imem_addr_o, model_pc);
      memq.push_back('{addr: model_pc, due: cyc + $urandom_range(lat_max, lat_min)});
      exp_q.push_back(model_pc);
      model_pc = model_pc + 32'd4;
    end
    @(posedge clk);
    #1;
    cyc++;
    if (imem_rvalid_i) void'(memq.pop_front());
    if (!rstn) begin
      memq.delete();
      exp_q.delete();
      model_pc = RST_PC;
    end else if (redir) begin
      exp_q.delete();
      model_pc = {rpc[31:2], 2'b00};
    end
  endtask

  task automatic run(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) step(1'b0, 32'd0, 1'b1);
  endtask

  // Monitor: the decode head must always match the oldest live granted fetch.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (rst_n_i && !redirect_i && id_valid_o) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_inst: got pc %h expected none", id_pc_o);
        end else begin
          chk("head_pc", id_pc_o, exp_q[0]);
          chk("head_inst", id_inst_o, memword(exp_q[0]));
          if (id_ready_i) begin
            void'(exp_q.pop_front());
            last_pop_pc = id_pc_o;
            n_pops++;
          end
        end
      end
    end
  end

  initial begin
    int unsigned p0;
    // Reset, then first fetch and no-bypass latency
    for (int i = 0; i < 3; i++) step(1'b0, 32'd0, 1'b0);
    step(1'b0, 32'd0, 1'b1);
    chk("first_req", {31'd0, s_req}, 32'd1);
    chk("first_addr", s_addr, RST_PC);
    chk("valid_cyc1", {31'd0, id_valid_o}, 32'd0);
    step(1'b0, 32'd0, 1'b1);
    chk("valid_cyc2", {31'd0, id_valid_o}, 32'd1);
    chk("pc_cyc2", id_pc_o, RST_PC);
    p0 = n_pops;
    run(20);
    chk("throughput", n_pops - p0, 32'd20);

    // Backpressure fills the FIFO and stalls requests
    rdy_pct = 0;
    run(10);
    chk("stall_req", {31'd0, s_req}, 32'd0);
    chk("stall_valid", {31'd0, id_valid_o}, 32'd1);
    rdy_pct = 100;
    run(10);

    // Redirect with stale responses in flight
    lat_min = 3; lat_max = 3;
    run(6);
    step(1'b1, 32'h0000_0100, 1'b1);
    p0 = n_pops;
    for (int i = 0; i < 30 && n_pops == p0; i++) run(1);
    chk("redir_first_pop", n_pops - p0, 32'd1);
    chk("redir_first_pc", last_pop_pc, 32'h0000_0100);

    // Redirect coinciding with a response and a pop
    lat_min = 1; lat_max = 1;
    run(8);
    step(1'b1, 32'h0000_0203, 1'b1);
    chk("redir_saw_rvalid", {31'd0, s_rvalid}, 32'd1);
    chk("redir_saw_pop", {31'd0, s_pop}, 32'd1);
    chk("redir_flush", {31'd0, id_valid_o}, 32'd0);
    step(1'b0, 32'd0, 1'b1);
    chk("redir_req", {31'd0, s_req}, 32'd1);
    chk("redir_addr", s_addr, 32'h0000_0200);
    run(6);

    // Grant withheld: request holds steady
    gnt_pct = 0;
    run(1);
    p0 = s_addr;
    for (int i = 0; i < 5; i++) begin
      run(1);
      chk("nogrant_req", {31'd0, s_req}, 32'd1);
      chk("nogrant_addr", s_addr, p0);
    end
    gnt_pct = 100;

    // PC wrap
    step(1'b1, 32'hFFFF_FFFC, 1'b1);
    step(1'b0, 32'd0, 1'b1);
    chk("wrap_addr0", s_addr, 32'hFFFF_FFFC);
    step(1'b0, 32'd0, 1'b1);
    chk("wrap_addr1", s_addr, 32'h0000_0000);
    run(8);

    // Reset mid-stream with requests outstanding
    lat_min = 3; lat_max = 3;
    run(6);
    step(1'b0, 32'd0, 1'b0);
    step(1'b0, 32'd0, 1'b1);
    chk("post_rst_req", {31'd0, s_req}, 32'd1);
    chk("post_rst_addr", s_addr, RST_PC);
    run(10);

    // Randomised traffic with random redirects
    gnt_pct = 70; rdy_pct = 60; lat_min = 1; lat_max = 4;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(99) < 3) step(1'b1, $urandom, 1'b1);
      else if ($urandom_range(999) < 2) step(1'b0, 32'd0, 1'b0);
      else step(1'b0, 32'd0, 1'b1);
    end
    gnt_pct = 100; rdy_pct = 100;
    run(20);
    chk("random_progress", {31'd0, n_pops > 1000}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
